// File: rtl/ctrl_interrupciones.sv
// Interrupt sequencer: edge-detects four IRQ lines, arbitrates them, forces a vector jump
// (annulling the current instruction), and restores the PC from epc on reti.
module ctrl_interrupciones #(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'('h3C0)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        irq,
   input  logic [5:0]        opcode,
   input  logic [ADDR_W-1:0] pc_actual,
   output logic              force_jmp,
   output logic              anula,
   output logic [ADDR_W-1:0] pc_dest,
   output logic [3:0]        iack,
   output logic              en_int,
   output logic              en_isr
);

   typedef enum logic [1:0] {IDLE, TAKE, IN_ISR} state_t;

   localparam logic [5:0] OP_EI   = 6'b111110;
   localparam logic [5:0] OP_RETI = 6'b111111;

   state_t            state;
   logic              ie;
   logic [3:0]        irq_q;
   logic [3:0]        pending;
   logic [1:0]        id;
   logic [ADDR_W-1:0] epc;

   logic [1:0] sel_id;
   logic [3:0] rise;
   logic [3:0] clr;
   logic       take;
   logic       is_reti;

   // Scan downward so the lowest pending index is the one left in sel_id.
   always_comb begin
      sel_id = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (pending[i]) sel_id = 2'(i);
   end

   assign rise    = irq & ~irq_q;
   assign take    = (state == IDLE) && ie && (pending != 4'b0);
   assign clr     = take ? (4'b0001 << sel_id) : 4'b0000;
   assign is_reti = (opcode == OP_RETI);
   assign en_int  = ie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ie      <= 1'b0;
         irq_q   <= 4'b0;
         pending <= 4'b0;
         id      <= 2'd0;
         epc     <= '0;
         en_isr  <= 1'b0;
      end else begin
         irq_q   <= irq;
         // A fresh edge on the line being cleared keeps the request alive.
         pending <= (pending & ~clr) | rise;
         case (state)
            IDLE: begin
               if (take) begin
                  state  <= TAKE;
                  id     <= sel_id;
                  ie     <= 1'b0;
                  en_isr <= 1'b1;
               end else if (opcode == OP_EI) begin
                  ie <= 1'b1;
               end
            end
            TAKE: begin
               epc   <= pc_actual;
               state <= IN_ISR;
            end
            IN_ISR: begin
               if (is_reti) begin
                  state  <= IDLE;
                  ie     <= 1'b1;
                  en_isr <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      force_jmp = 1'b0;
      anula     = 1'b0;
      pc_dest   = '0;
      iack      = 4'b0;
      case (state)
         TAKE: begin
            force_jmp = 1'b1;
            anula     = 1'b1;
            pc_dest   = VEC_BASE + ADDR_W'({id, 2'b00});
            iack      = 4'b0001 << id;
         end
         IN_ISR: begin
            if (is_reti) begin
               force_jmp = 1'b1;
               pc_dest   = epc;
            end
         end
         default: ;
      endcase
   end

endmodule
